// File: rtl/cmd_uart_rx_if.sv
// Command-link bundle between the serial front end and the command consumer.
// The slave side is the receiver. The master side drives the RX line and
// acknowledges commands.
interface cmd_uart_rx_if;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;
  logic        overrun;

  modport master (
    output RX,
    output clr_cmd_rdy,
    input  cmd,
    input  cmd_rdy,
    input  frm_err,
    input  overrun
  );

  modport slave (
    input  RX,
    input  clr_cmd_rdy,
    output cmd,
    output cmd_rdy,
    output frm_err,
    output overrun
  );
endinterface

// File: rtl/cmd_uart_rx.sv
// 8N1 UART receiver. It pairs consecutive bytes, high byte first, into a
// 16-bit command word and holds a sticky ready flag. A high byte that waits
// too long for its partner is dropped. So is a pair broken by a framing error.
module cmd_uart_rx #(
  parameter int BAUD_DIV     = 5208,
  parameter int BYTE_TIMEOUT = 208320
) (
  input  logic         clk,
  input  logic         rst,
  cmd_uart_rx_if.slave bus
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  // First expiry lands mid start bit.
  localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2);
  // Each later expiry follows exactly BAUD_DIV clocks after the previous one.
  // The expiry cycle itself is one of those clocks, hence the minus one.
  localparam logic [CW-1:0] BIT_CNT  = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(BYTE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

  logic            rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic            rx_s, fall_s, expire_s;
  rx_state_t       rx_state_r, rx_state_s;
  logic [CW-1:0]   baud_cnt_r, baud_cnt_s;
  logic [2:0]      bit_cnt_r, bit_cnt_s;
  logic [7:0]      shift_r, shift_s;
  logic            byte_done_r, byte_done_s;
  logic            frm_err_r, frm_err_s;

  asm_state_t      asm_state_r, asm_state_s;
  logic [7:0]      hi_r, hi_s;
  logic [TW-1:0]   to_cnt_r, to_cnt_s;
  logic            load_cmd_s;
  logic [15:0]     new_cmd_s;
  logic [15:0]     cmd_r;
  logic            cmd_rdy_r, overrun_r;

  assign rx_s     = rx_sync2_r;
  assign fall_s   = ~rx_sync2_r & rx_prev_r;
  assign expire_s = (baud_cnt_r == {CW{1'b0}});

  assign bus.cmd     = cmd_r;
  assign bus.cmd_rdy = cmd_rdy_r;
  assign bus.frm_err = frm_err_r;
  assign bus.overrun = overrun_r;

  // Two-flop synchroniser on RX, plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= bus.RX;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  // Bit-level receiver: next state, baud counter, shift register and byte flags.
  always_comb begin
    rx_state_s  = rx_state_r;
    baud_cnt_s  = baud_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    byte_done_s = 1'b0;
    frm_err_s   = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (fall_s) begin
          rx_state_s = RX_START;
          baud_cnt_s = HALF_CNT;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (expire_s) begin
          if (!rx_s) begin
            rx_state_s = RX_DATA;
            baud_cnt_s = BIT_CNT;
            bit_cnt_s  = 3'd0;
          end else begin
            // The line is high again at mid start bit, so this was a glitch.
            rx_state_s = RX_IDLE;
          end
        end else begin
          baud_cnt_s = baud_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      RX_DATA: begin
        if (expire_s) begin
          shift_s    = {rx_s, shift_r[7:1]};
          baud_cnt_s = BIT_CNT;
          if (bit_cnt_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      RX_STOP: begin
        if (expire_s) begin
          if (rx_s) begin
            byte_done_s = 1'b1;
          end else begin
            frm_err_s = 1'b1;
          end
          rx_state_s = RX_IDLE;
        end else begin
          baud_cnt_s = baud_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
      end
    endcase
  end

  // Bit-level receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r  <= RX_IDLE;
      baud_cnt_r  <= {CW{1'b0}};
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      byte_done_r <= 1'b0;
      frm_err_r   <= 1'b0;
    end else begin
      rx_state_r  <= rx_state_s;
      baud_cnt_r  <= baud_cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      byte_done_r <= byte_done_s;
      frm_err_r   <= frm_err_s;
    end
  end

  // Byte pairing. It stores the high byte and waits a bounded time for the low byte.
  always_comb begin
    asm_state_s = asm_state_r;
    hi_s        = hi_r;
    to_cnt_s    = to_cnt_r;
    load_cmd_s  = 1'b0;
    new_cmd_s   = {hi_r, shift_r};
    case (asm_state_r)
      WAIT_HI: begin
        if (byte_done_r) begin
          hi_s        = shift_r;
          to_cnt_s    = {TW{1'b0}};
          asm_state_s = WAIT_LO;
        end else begin
          asm_state_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (byte_done_r) begin
          load_cmd_s  = 1'b1;
          asm_state_s = WAIT_HI;
        end else if (frm_err_r) begin
          asm_state_s = WAIT_HI;
        end else if (to_cnt_r == TO_LAST) begin
          asm_state_s = WAIT_HI;
        end else begin
          to_cnt_s = to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        asm_state_s = WAIT_HI;
      end
    endcase
  end

  // Pairing state, command word, sticky ready flag and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state_r <= WAIT_HI;
      hi_r        <= 8'h00;
      to_cnt_r    <= {TW{1'b0}};
      cmd_r       <= 16'h0000;
      cmd_rdy_r   <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      asm_state_r <= asm_state_s;
      hi_r        <= hi_s;
      to_cnt_r    <= to_cnt_s;
      if (load_cmd_s) begin
        cmd_r     <= new_cmd_s;
        cmd_rdy_r <= 1'b1;
        overrun_r <= cmd_rdy_r;
      end else begin
        overrun_r <= 1'b0;
        if (bus.clr_cmd_rdy) begin
          cmd_rdy_r <= 1'b0;
        end else begin
          cmd_rdy_r <= cmd_rdy_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_uart_rx.sv
// Bench for cmd_uart_rx. A transaction-level model predicts every output on
// every cycle. Each frame start predicts when the receiver finishes that byte.
// Byte pairing, timeout, framing and ready/overrun rules are applied to those
// completions.
module tb_cmd_uart_rx;
  localparam int B  = 16;
  localparam int TO = 400;
  // Cycle, counted from the frame start, on which the byte-finished pulse is visible.
  localparam int DONE_OFS = 4 + B / 2 + 9 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_uart_rx_if bus();

  cmd_uart_rx #(.BAUD_DIV(B), .BYTE_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       ok;
  } ev_t;

  ev_t         evq[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        rst_q = 1'b1;
  logic        clr_q = 1'b0;
  logic        chk_en = 1'b0;

  // model state
  logic [15:0] exp_cmd = 16'h0000;
  logic        exp_rdy = 1'b0;
  logic        exp_frm, exp_ovr;
  logic        hi_valid = 1'b0;
  logic [7:0]  hi_byte = 8'h00;
  int          hi_at = 0;
  logic        pend_valid = 1'b0;
  int          pend_at = 0;
  logic [15:0] pend_cmd = 16'h0000;
  ev_t         ev;

  // observation counters
  int          frm_seen = 0;
  int          ovr_seen = 0;
  int          rise_cyc = -1;
  logic        prev_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // cycle counter and the control inputs as the DUT saw them on each edge
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    clr_q <= bus.clr_cmd_rdy;
  end

  // reference model and per-cycle compare
  always @(negedge clk) begin
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
    if (rst_q) begin
      exp_cmd    = 16'h0000;
      exp_rdy    = 1'b0;
      hi_valid   = 1'b0;
      pend_valid = 1'b0;
      evq.delete();
    end else begin
      if (pend_valid && cyc == pend_at) begin
        exp_ovr    = exp_rdy;
        exp_cmd    = pend_cmd;
        exp_rdy    = 1'b1;
        pend_valid = 1'b0;
      end else if (clr_q) begin
        exp_rdy = 1'b0;
      end
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        if (!ev.ok) begin
          exp_frm  = 1'b1;
          hi_valid = 1'b0;
        end else if (hi_valid && (cyc - hi_at) <= TO) begin
          pend_valid = 1'b1;
          pend_at    = cyc + 1;
          pend_cmd   = {hi_byte, ev.data};
          hi_valid   = 1'b0;
        end else begin
          hi_valid = 1'b1;
          hi_byte  = ev.data;
          hi_at    = cyc;
        end
      end
    end
    if (chk_en) begin
      check("cmd", 32'(bus.cmd), 32'(exp_cmd));
      check("cmd_rdy", 32'(bus.cmd_rdy), 32'(exp_rdy));
      check("frm_err", 32'(bus.frm_err), 32'(exp_frm));
      check("overrun", 32'(bus.overrun), 32'(exp_ovr));
      if (bus.frm_err === 1'b1) frm_seen++;
      if (bus.overrun === 1'b1) ovr_seen++;
      if (bus.cmd_rdy === 1'b1 && prev_rdy !== 1'b1) rise_cyc = cyc;
    end
    prev_rdy = bus.cmd_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, LSB first. rst_bit >= 0 pulses reset at that bit position
  // and abandons the rest of the frame.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int rst_bit);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    evq.push_back('{due: cyc + DONE_OFS, data: d, ok: stop});
    for (int i = 0; i < 10; i++) begin
      if (i == rst_bit) begin
        bus.RX = 1'b1;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2 * B) tick();
        return;
      end
      bus.RX = fr[i];
      repeat (B) tick();
    end
    bus.RX = 1'b1;
  endtask

  task automatic clear_rdy();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    repeat (2 * B) tick();
  endtask

  initial begin
    int c_lo;
    bus.RX          = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    rst             = 1'b1;
    repeat (3) tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_cmd", 32'(bus.cmd), 32'h0);
    check("reset_rdy", 32'(bus.cmd_rdy), 32'h0);
    check("reset_frm", 32'(bus.frm_err), 32'h0);
    check("reset_ovr", 32'(bus.overrun), 32'h0);
    repeat (4) tick();

    // 1: first command, exact latency, then acknowledge
    rise_cyc = -1;
    send_byte(8'h00, 1'b1, -1);
    c_lo = cyc;
    send_byte(8'h01, 1'b1, -1);
    repeat (4) tick();
    check("t1_latency", 32'(rise_cyc), 32'(c_lo + 157));
    check("t1_cmd", 32'(bus.cmd), 32'h0001);
    check("t1_rdy", 32'(bus.cmd_rdy), 32'h1);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    check("t1_clr_rdy", 32'(bus.cmd_rdy), 32'h0);
    check("t1_cmd_hold", 32'(bus.cmd), 32'h0001);
    repeat (2 * B) tick();

    // 2: overwrite while ready, with the acknowledge colliding with completion
    ovr_seen = 0;
    send_byte(8'hA5, 1'b1, -1);
    send_byte(8'h3C, 1'b1, -1);
    fork
      begin
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h34, 1'b1, -1);
      end
      begin
        repeat (160 + 156) tick();
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
      end
    join
    repeat (4) tick();
    check("t2_cmd", 32'(bus.cmd), 32'h1234);
    check("t2_rdy", 32'(bus.cmd_rdy), 32'h1);
    check("t2_overruns", 32'(ovr_seen), 32'd1);
    clear_rdy();

    // 3: short low glitch is rejected at the start-bit check
    frm_seen = 0;
    bus.RX = 1'b0;
    repeat (4) tick();
    bus.RX = 1'b1;
    repeat (2 * B) tick();
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h03, 1'b1, -1);
    repeat (4) tick();
    check("t3_frm", 32'(frm_seen), 32'd0);
    check("t3_cmd", 32'(bus.cmd), 32'h0003);
    clear_rdy();

    // 4: lone high byte times out
    send_byte(8'hFF, 1'b1, -1);
    repeat (500) tick();
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h02, 1'b1, -1);
    repeat (4) tick();
    check("t4_cmd", 32'(bus.cmd), 32'h0002);
    clear_rdy();

    // 5: framing error, then a clean pair
    frm_seen = 0;
    send_byte(8'h55, 1'b0, -1);
    bus.RX = 1'b1;
    repeat (2 * B) tick();
    check("t5_no_rdy", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h01, 1'b1, -1);
    repeat (4) tick();
    check("t5_frm", 32'(frm_seen), 32'd1);
    check("t5_cmd", 32'(bus.cmd), 32'h0001);
    clear_rdy();

    // 6: reset in the middle of the low byte, then a clean pair
    send_byte(8'h12, 1'b1, -1);
    send_byte(8'h34, 1'b1, 5);
    check("t6_rst_cmd", 32'(bus.cmd), 32'h0000);
    check("t6_rst_rdy", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'hBE, 1'b1, -1);
    send_byte(8'hEF, 1'b1, -1);
    repeat (4) tick();
    check("t6_cmd", 32'(bus.cmd), 32'hBEEF);
    check("t6_rdy", 32'(bus.cmd_rdy), 32'h1);
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
